// File: rtl/fir_interp_pkg.sv
// Shared constants, state encoding and saturation helper for the 2x interpolating FIR.
// Optional rounding is selected with FIR_INTERP_ROUND_EN (see fir_interp_phase_sum).
package fir_interp_pkg;

  localparam int N     = 16;
  localparam int CW    = 6;
  localparam int SHIFT = 5;
  localparam int ACC_W = N + CW + 2;

  // Prototype low-pass taps; even phase uses H2/H4/H6(/H8), odd phase H1/H3/H5/H7.
  localparam logic [CW-1:0] H0 = 6'd0;
  localparam logic [CW-1:0] H1 = 6'd1;
  localparam logic [CW-1:0] H2 = 6'd7;
  localparam logic [CW-1:0] H3 = 6'd15;
  localparam logic [CW-1:0] H4 = 6'd19;
  localparam logic [CW-1:0] H5 = 6'd15;
  localparam logic [CW-1:0] H6 = 6'd7;
  localparam logic [CW-1:0] H7 = 6'd1;
  localparam logic [CW-1:0] H8 = 6'd0;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH0  = 2'd1,
    PH1  = 2'd2
  } state_e;

  function automatic logic signed [N-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [N-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[N-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[N-1:0];
    else                  r = v[N-1:0];
    return r;
  endfunction

endpackage

// File: rtl/fir_interp_x2_if.sv
// Sample stream bundle for fir_interp_x2: input handshake, output handshake, FSM debug view.
// Handshakes: a word moves when valid & ready are both 1 on a rising edge; a held valid word never changes until taken.
interface fir_interp_x2_if;
  import fir_interp_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] data_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] data_out;
  state_e              dbg_state;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, dbg_state
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, dbg_state
  );

endinterface

// File: rtl/fir_interp_phase_sum.sv
// Combinational polyphase sum for one output phase, then scale, optional round, saturate.
// FIR_INTERP_ROUND_EN adds half an LSB before the arithmetic shift (round half up).
module fir_interp_phase_sum
  import fir_interp_pkg::*;
(
  input  logic signed [N-1:0] r0,
  input  logic signed [N-1:0] r1,
  input  logic signed [N-1:0] r2,
  input  logic signed [N-1:0] r3,
  input  logic                odd,
  output logic signed [N-1:0] y
);

  function automatic logic signed [ACC_W-1:0] tap(input logic signed [N-1:0] x,
                                                  input logic [CW-1:0] h);
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] he;
    xe = {{(ACC_W-N){x[N-1]}}, x};
    he = {{(ACC_W-CW){1'b0}}, h};
    return xe * he;
  endfunction

  logic signed [ACC_W-1:0] even_acc;
  logic signed [ACC_W-1:0] odd_acc;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] scaled;

`ifdef FIR_INTERP_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (SHIFT - 1);
`endif

  // H0 would weight the not-yet-accepted sample and is zero, so it has no term.
  always_comb begin
    even_acc = tap(r0, H2) + tap(r1, H4) + tap(r2, H6) + tap(r3, H8);
    odd_acc  = tap(r0, H1) + tap(r1, H3) + tap(r2, H5) + tap(r3, H7);
    acc      = odd ? odd_acc : even_acc;
`ifdef FIR_INTERP_ROUND_EN
    acc_r    = acc + ROUND_BIAS;
`else
    acc_r    = acc;
`endif
    scaled   = acc_r >>> SHIFT;
    y        = saturate(scaled);
  end

endmodule

// File: rtl/fir_interp_x2.sv
// 2x interpolating polyphase FIR: one input sample yields an even then an odd output sample.
// Build option FIR_INTERP_ROUND_EN selects round-half-up scaling instead of floor.
module fir_interp_x2
  import fir_interp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fir_interp_x2_if.slave    bus
);

  state_e              state_q, state_d;
  logic signed [N-1:0] r0_q, r0_d;
  logic signed [N-1:0] r1_q, r1_d;
  logic signed [N-1:0] r2_q, r2_d;
  logic signed [N-1:0] r3_q, r3_d;
  logic signed [N-1:0] dout_q, dout_d;

  logic                in_ready_c;
  logic                accept;
  logic                odd_sel;
  logic signed [N-1:0] phase_y;

  // On accept the registers still hold pre-shift history (even phase); in PH0 they hold post-shift history (odd phase).
  fir_interp_phase_sum u_phase_sum (
    .r0  (r0_q),
    .r1  (r1_q),
    .r2  (r2_q),
    .r3  (r3_q),
    .odd (odd_sel),
    .y   (phase_y)
  );

  always_comb begin
    state_d    = state_q;
    r0_d       = r0_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    dout_d     = dout_q;
    in_ready_c = (state_q == IDLE) || ((state_q == PH1) && bus.out_ready);
    accept     = bus.in_valid && in_ready_c;
    odd_sel    = (state_q == PH0);

    case (state_q)
      IDLE: ;
      PH0: begin
        if (bus.out_ready) begin
          dout_d  = phase_y;
          state_d = PH1;
        end
      end
      PH1: begin
        if (bus.out_ready && !bus.in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dout_d  = phase_y;
      r0_d    = bus.data_in;
      r1_d    = r0_q;
      r2_d    = r1_q;
      r3_d    = r2_q;
      state_d = PH0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q != IDLE);
  assign bus.data_out  = dout_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fir_interp_x2.sv
// Bench for fir_interp_x2: directed vectors with hand-computed even/odd outputs fed to a scoreboard.
// Expected values follow the FIR_INTERP_ROUND_EN build option when it is defined.
module tb_fir_interp_x2;
  import fir_interp_pkg::*;

`ifdef FIR_INTERP_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fir_interp_x2_if bus();

  fir_interp_x2 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard state
  logic [N-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int gap_cnt = 0;
  bit gap_chk = 1'b0;
  int last_wait;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // monitor: a word transfers on the next rising edge whenever valid & ready are seen here
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got %0d with empty expected queue at %0t",
                 $signed(bus.data_out), $time);
      end else begin
        logic [N-1:0] e;
        e = exp_q.pop_front();
        check("data_out", int'($signed(bus.data_out)), int'($signed(e)));
      end
    end
    if (gap_chk && !bus.out_valid) gap_cnt++;
  end

  // driver: present x until accepted, then queue its even and odd expectations
  task automatic sv(input int x, input int e, input int o);
    int waited;
    bus.in_valid = 1'b1;
    bus.data_in  = x[N-1:0];
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 50);
    if (!bus.in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      exp_q.push_back(e[N-1:0]);
      exp_q.push_back(o[N-1:0]);
    end
    last_wait = waited;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int cyc;
    bus.in_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((exp_q.size() != 0 || bus.out_valid) && cyc < 100);
    if (exp_q.size() != 0 || bus.out_valid) begin
      n_total++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic impulse();
    sv(32, 0, 1);
    sv(0, 7, 15);
    sv(0, 19, 15);
    sv(0, 7, 1);
    sv(0, 0, 0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_data_out", int'($signed(bus.data_out)), 0);
    check("reset_state", int'(bus.dbg_state), int'(IDLE));
    reset = 1'b0;

    impulse();

    // backpressure while the even sample is held
    sv(64, 0, 2);
    drain();
    bus.out_ready = 1'b0;
    sv(0, 14, 30);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(bus.out_valid), 1);
      check("bp_data_out", int'($signed(bus.data_out)), 14);
      check("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    sv(0, 38, 30);
    sv(0, 14, 2);
    sv(0, 0, 0);
    drain();

    // DC -1000 streamed: one accept every 2 cycles, out_valid never drops
    sv(-1000, 0, RND ? -31 : -32);
    gap_cnt = 0;
    gap_chk = 1'b1;
    sv(-1000, -219, -500);
    check("stream_accept_period", last_wait, 2);
    sv(-1000, RND ? -812 : -813, -969);
    check("stream_accept_period", last_wait, 2);
    sv(-1000, RND ? -1031 : -1032, -1000);
    check("stream_accept_period", last_wait, 2);
    sv(-1000, RND ? -1031 : -1032, -1000);
    check("stream_accept_period", last_wait, 2);
    sv(-1000, RND ? -1031 : -1032, -1000);
    check("stream_accept_period", last_wait, 2);
    gap_chk = 1'b0;
    check("stream_out_valid_gaps", gap_cnt, 0);
    sv(0, RND ? -1031 : -1032, -969);
    sv(0, RND ? -812 : -813, -500);
    sv(0, -219, RND ? -31 : -32);
    sv(0, 0, 0);
    drain();

    // positive saturation
    sv(32767, 0, RND ? 1024 : 1023);
    sv(32767, RND ? 7168 : 7167, RND ? 16384 : 16383);
    sv(32767, 26623, 31743);
    sv(32767, 32767, 32767);
    sv(32767, 32767, 32767);
    drain();

    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // negative saturation from cleared history
    sv(-32768, 0, -1024);
    sv(-32768, -7168, -16384);
    sv(-32768, -26624, -31744);
    sv(-32768, -32768, -32768);
    sv(-32768, -32768, -32768);
    drain();

    // reset while the even sample is held discards it
    bus.out_ready = 1'b0;
    sv(32, -32768, 0);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_ph0_out_valid", int'(bus.out_valid), 0);
    check("rst_ph0_in_ready", int'(bus.in_ready), 1);
    check("rst_ph0_data_out", int'($signed(bus.data_out)), 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    impulse();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
